// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core and debug request ports plus the data memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  core_req_i;
  logic                  core_we_i;
  logic [DATA_W/8-1:0]   core_be_i;
  logic [ADDR_W-1:0]     core_addr_i;
  logic [DATA_W-1:0]     core_wdata_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [DATA_W-1:0]     core_rdata_o;
  logic                  core_stall_o;

  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [DATA_W/8-1:0]   dbg_be_i;
  logic [ADDR_W-1:0]     dbg_addr_i;
  logic [DATA_W-1:0]     dbg_wdata_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [DATA_W-1:0]     dbg_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
    output dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency single-port data memory between the core and debug ports.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise the core port has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_DBG  = 1'b1;
  localparam logic [3:0] LAT_C    = 4'(MEM_LATENCY);

  if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_lat_chk
    $error("dmem_arbiter: MEM_LATENCY must lie in 1..15");
  end

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        cnt_r;
  logic              owner_r;
  logic              winner_s;
  logic              any_req_s;
  logic              grant_s;
  logic              done_s;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [BE_W-1:0]   mem_be_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  assign any_req_s = bus.core_req_i | bus.dbg_req_i;
  assign grant_s   = (state_r == ST_IDLE) & any_req_s;
  assign done_s    = (state_r == ST_WAIT) & (cnt_r == 4'd1);

`ifdef DMEM_ARB_RR_EN
  logic last_owner_r;

  // Tie goes to the port that was not granted last.
  always_comb begin
    if (bus.core_req_i && bus.dbg_req_i) begin
      winner_s = ~last_owner_r;
    end else if (bus.core_req_i) begin
      winner_s = OWN_CORE;
    end else begin
      winner_s = OWN_DBG;
    end
  end

  // Remember who won the most recent grant; starts as dbg so core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_r <= OWN_DBG;
    end else if (grant_s) begin
      last_owner_r <= winner_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Fixed priority: core always beats dbg.
  always_comb begin
    if (bus.core_req_i) begin
      winner_s = OWN_CORE;
    end else begin
      winner_s = OWN_DBG;
    end
  end
`endif

  // Next-state decode for the IDLE -> ISSUE -> WAIT sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = any_req_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT:  state_nxt_s = done_s ? ST_IDLE : ST_WAIT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latency counter, owner and the latched memory command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      owner_r     <= OWN_CORE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= {BE_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      mem_req_r <= grant_s;
      case (state_r)
        ST_ISSUE: cnt_r <= LAT_C;
        ST_WAIT:  cnt_r <= cnt_r - 4'd1;
        default:  cnt_r <= 4'd0;
      endcase
      if (grant_s) begin
        owner_r <= winner_s;
        if (winner_s == OWN_CORE) begin
          mem_we_r    <= bus.core_we_i;
          mem_be_r    <= bus.core_be_i;
          mem_addr_r  <= bus.core_addr_i;
          mem_wdata_r <= bus.core_wdata_i;
        end else begin
          mem_we_r    <= bus.dbg_we_i;
          mem_be_r    <= bus.dbg_be_i;
          mem_addr_r  <= bus.dbg_addr_i;
          mem_wdata_r <= bus.dbg_wdata_i;
        end
      end else begin
        owner_r     <= owner_r;
        mem_we_r    <= mem_we_r;
        mem_be_r    <= mem_be_r;
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  // Grants are gated by rst_n so a request held through reset never sees a grant pulse.
  always_comb begin
    bus.core_gnt_o    = rst_n & grant_s & (winner_s == OWN_CORE);
    bus.dbg_gnt_o     = rst_n & grant_s & (winner_s == OWN_DBG);
    bus.core_rvalid_o = done_s & (owner_r == OWN_CORE);
    bus.dbg_rvalid_o  = done_s & (owner_r == OWN_DBG);
    if (bus.core_rvalid_o && !mem_we_r) begin
      bus.core_rdata_o = bus.mem_rdata_i;
    end else begin
      bus.core_rdata_o = {DATA_W{1'b0}};
    end
    if (bus.dbg_rvalid_o && !mem_we_r) begin
      bus.dbg_rdata_o = bus.mem_rdata_i;
    end else begin
      bus.dbg_rdata_o = {DATA_W{1'b0}};
    end
    bus.core_stall_o = bus.core_req_i & ~bus.core_rvalid_o;
    bus.mem_req_o    = mem_req_r;
    bus.mem_we_o     = mem_we_r;
    bus.mem_be_o     = mem_be_r;
    bus.mem_addr_o   = mem_addr_r;
    bus.mem_wdata_o  = mem_wdata_r;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: timing checks inline per scenario, read data via scoreboards.
// Instance u_dut uses MEM_LATENCY=2, u_dut1 uses MEM_LATENCY=1 for the back-to-back scenario.
module tb_dmem_arbiter;
  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_mode = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  int          tests = 0;
  int          fails = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon_e0;
  exp_t        mon_e1;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // Memory models: either a fixed word or a word derived from the latched address.
  assign bus.mem_rdata_i  = rd_mode ? (bus.mem_addr_o ^ 32'h5A5A_0000) : fixed_rdata;
  assign bus1.mem_rdata_i = bus1.mem_addr_o ^ 32'hC3C3_0000;

  // Scoreboard for u_dut: every rvalid pops the oldest expected result.
  always @(negedge clk) begin
    if (bus.core_rvalid_o || bus.dbg_rvalid_o) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL sb0_unexpected_rvalid core=%b dbg=%b expected none", bus.core_rvalid_o, bus.dbg_rvalid_o);
      end else begin
        mon_e0 = q0.pop_front();
        if (bus.core_rvalid_o && bus.dbg_rvalid_o) begin
          fails++;
          $display("FAIL sb0_both_rvalid got both expected one");
        end else if ({bus.dbg_rvalid_o, (bus.dbg_rvalid_o ? bus.dbg_rdata_o : bus.core_rdata_o)} !== mon_e0) begin
          fails++;
          $display("FAIL sb0_result got port=%b data=%h expected port=%b data=%h", bus.dbg_rvalid_o,
                   (bus.dbg_rvalid_o ? bus.dbg_rdata_o : bus.core_rdata_o), mon_e0.port, mon_e0.data);
        end
      end
    end
  end

  // Scoreboard for u_dut1 (core port only in use).
  always @(negedge clk) begin
    if (bus1.core_rvalid_o || bus1.dbg_rvalid_o) begin
      tests++;
      if (q1.size() == 0 || bus1.dbg_rvalid_o) begin
        fails++;
        $display("FAIL sb1_unexpected_rvalid core=%b dbg=%b", bus1.core_rvalid_o, bus1.dbg_rvalid_o);
      end else begin
        mon_e1 = q1.pop_front();
        if (bus1.core_rdata_o !== mon_e1.data) begin
          fails++;
          $display("FAIL sb1_result got data=%h expected data=%h", bus1.core_rdata_o, mon_e1.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [69:0] mem_v;
    logic [67:0] out_v;
    bus.core_req_i = 1'b1;
    @(negedge clk);
    mem_v = {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o};
    out_v = {bus.core_gnt_o, bus.core_rvalid_o, bus.dbg_gnt_o, bus.dbg_rvalid_o, bus.core_rdata_o, bus.dbg_rdata_o};
    tests++; if (mem_v !== 70'd0) begin fails++; $display("FAIL reset_mem got=%h expected 0", mem_v); end
    tests++; if (out_v !== 68'd0) begin fails++; $display("FAIL reset_outputs got=%h expected 0", out_v); end
    tests++; if (bus.core_stall_o !== 1'b1) begin fails++; $display("FAIL reset_stall got=%b expected 1", bus.core_stall_o); end
    bus.core_req_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.core_gnt_o, bus.dbg_gnt_o, bus.mem_req_o, bus.core_stall_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_idle got=%b expected 0000", {bus.core_gnt_o, bus.dbg_gnt_o, bus.mem_req_o, bus.core_stall_o});
    end
  endtask

  task automatic test_core_load();
    rd_mode = 1'b0;
    fixed_rdata = 32'hDEAD_BEEF;
    q0.push_back(exp_t'{1'b0, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    bus.core_we_i = 1'b0; bus.core_be_i = 4'hF; bus.core_addr_i = 32'h40; bus.core_req_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++; if (bus.core_gnt_o !== 1'(c == 0)) begin fails++; $display("FAIL load_gnt c=%0d got=%b", c, bus.core_gnt_o); end
      tests++; if (bus.mem_req_o !== 1'(c == 1)) begin fails++; $display("FAIL load_mem_req c=%0d got=%b", c, bus.mem_req_o); end
      tests++; if (bus.core_rvalid_o !== 1'(c == 3)) begin fails++; $display("FAIL load_rvalid c=%0d got=%b", c, bus.core_rvalid_o); end
      tests++; if (bus.core_stall_o !== 1'(c <= 2)) begin fails++; $display("FAIL load_stall c=%0d got=%b", c, bus.core_stall_o); end
      if (c == 1) begin
        tests++;
        if ({bus.mem_we_o, bus.mem_addr_o} !== {1'b0, 32'h40}) begin
          fails++; $display("FAIL load_mem_cmd got we=%b addr=%h expected we=0 addr=40", bus.mem_we_o, bus.mem_addr_o);
        end
      end
      if (bus.core_rvalid_o) bus.core_req_i = 1'b0;
    end
  endtask

  task automatic test_core_store();
    q0.push_back(exp_t'{1'b0, 32'h0});
    @(posedge clk); #1;
    bus.core_we_i = 1'b1; bus.core_be_i = 4'b0011; bus.core_addr_i = 32'h100;
    bus.core_wdata_i = 32'h1234_5678; bus.core_req_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++; if (bus.core_rvalid_o !== 1'(c == 3)) begin fails++; $display("FAIL store_rvalid c=%0d got=%b", c, bus.core_rvalid_o); end
      if (c == 1) begin
        tests++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !==
            {1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678}) begin
          fails++; $display("FAIL store_mem_cmd got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0011 100 12345678",
                            bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
      end
      if (bus.core_rvalid_o) bus.core_req_i = 1'b0;
    end
    bus.core_we_i = 1'b0;
  endtask

  task automatic test_arbitration();
    do_reset();
    rd_mode = 1'b1;
    q0.push_back(exp_t'{1'b0, 32'h80 ^ 32'h5A5A_0000});
    q0.push_back(exp_t'{1'b1, 32'h200 ^ 32'h5A5A_0000});
    @(posedge clk); #1;
    bus.core_we_i = 1'b0; bus.core_addr_i = 32'h80; bus.core_req_i = 1'b1;
    bus.dbg_we_i = 1'b0; bus.dbg_be_i = 4'hF; bus.dbg_addr_i = 32'h200; bus.dbg_req_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (bus.core_gnt_o !== 1'(c == 0)) begin fails++; $display("FAIL arb_core_gnt c=%0d got=%b", c, bus.core_gnt_o); end
      tests++; if (bus.dbg_gnt_o !== 1'(c == 4)) begin fails++; $display("FAIL arb_dbg_gnt c=%0d got=%b", c, bus.dbg_gnt_o); end
      tests++; if (bus.dbg_rvalid_o !== 1'(c == 7)) begin fails++; $display("FAIL arb_dbg_rvalid c=%0d got=%b", c, bus.dbg_rvalid_o); end
      if (c == 5) begin
        tests++; if (bus.mem_addr_o !== 32'h200) begin fails++; $display("FAIL arb_dbg_addr got=%h expected 200", bus.mem_addr_o); end
      end
      if (bus.core_rvalid_o) bus.core_req_i = 1'b0;
      if (bus.dbg_rvalid_o) bus.dbg_req_i = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    logic exp_port;
    int   g = 0;
    int   r = 0;
    do_reset();
    rd_mode = 1'b1;
    @(posedge clk); #1;
    bus.core_addr_i = 32'h84; bus.dbg_addr_i = 32'h204;
    bus.core_req_i = 1'b1; bus.dbg_req_i = 1'b1;
    for (int c = 0; c < 40 && r < 4; c++) begin
      @(negedge clk);
      if (bus.core_gnt_o || bus.dbg_gnt_o) begin
`ifdef DMEM_ARB_RR_EN
        exp_port = 1'(g % 2);
`else
        exp_port = 1'b0;
`endif
        q0.push_back(exp_t'{exp_port, (exp_port ? 32'h204 : 32'h84) ^ 32'h5A5A_0000});
        tests++;
        if ({bus.core_gnt_o, bus.dbg_gnt_o} !== {~exp_port, exp_port}) begin
          fails++; $display("FAIL rr_order grant=%0d got core=%b dbg=%b expected dbg=%b", g, bus.core_gnt_o, bus.dbg_gnt_o, exp_port);
        end
        tests++; if (c !== g * 4) begin fails++; $display("FAIL rr_spacing grant=%0d got cycle=%0d expected %0d", g, c, g * 4); end
        g++;
      end
      if (bus.core_rvalid_o || bus.dbg_rvalid_o) r++;
      if (r == 4) begin bus.core_req_i = 1'b0; bus.dbg_req_i = 1'b0; end
    end
    tests++; if (r !== 4) begin fails++; $display("FAIL rr_timeout got %0d rvalids expected 4", r); end
    bus.core_req_i = 1'b0; bus.dbg_req_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [73:0] all_v;
    @(posedge clk); #1;
    bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 32'h300; bus.dbg_req_i = 1'b1;
    @(negedge clk);
    tests++; if (bus.dbg_gnt_o !== 1'b1) begin fails++; $display("FAIL rstmid_gnt got=%b expected 1", bus.dbg_gnt_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    all_v = {bus.core_gnt_o, bus.core_rvalid_o, bus.dbg_gnt_o, bus.dbg_rvalid_o, bus.core_stall_o,
             bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o};
    tests++; if (all_v !== 74'd0) begin fails++; $display("FAIL rstmid_outputs got=%h expected 0", all_v); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.dbg_gnt_o, bus.dbg_rvalid_o} !== 2'b00) begin
        fails++; $display("FAIL rstmid_hold c=%0d got gnt=%b rvalid=%b expected 00", c, bus.dbg_gnt_o, bus.dbg_rvalid_o);
      end
    end
    bus.dbg_req_i = 1'b0;
    q0.push_back(exp_t'{1'b0, 32'h44 ^ 32'h5A5A_0000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.core_we_i = 1'b0; bus.core_addr_i = 32'h44; bus.core_req_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (bus.core_gnt_o !== 1'(c == 0)) begin fails++; $display("FAIL rstmid_fresh_gnt c=%0d got=%b", c, bus.core_gnt_o); end
      tests++; if (bus.core_rvalid_o !== 1'(c == 3)) begin fails++; $display("FAIL rstmid_fresh_rvalid c=%0d got=%b", c, bus.core_rvalid_o); end
      if (bus.core_rvalid_o) bus.core_req_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int k = 0;
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18;
    for (int i = 0; i < 3; i++) q1.push_back(exp_t'{1'b0, addrs[i] ^ 32'hC3C3_0000});
    @(posedge clk); #1;
    bus1.core_we_i = 1'b0; bus1.core_addr_i = addrs[0]; bus1.core_req_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++; if (bus1.core_gnt_o !== 1'((c % 3 == 0) && (c < 9))) begin fails++; $display("FAIL b2b_gnt c=%0d got=%b", c, bus1.core_gnt_o); end
      tests++; if (bus1.core_rvalid_o !== 1'((c % 3 == 2) && (c < 9))) begin fails++; $display("FAIL b2b_rvalid c=%0d got=%b", c, bus1.core_rvalid_o); end
      if (bus1.core_rvalid_o) begin
        k++;
        if (k >= 3) bus1.core_req_i = 1'b0;
        else bus1.core_addr_i = addrs[k];
      end
    end
    bus1.core_req_i = 1'b0;
  endtask

  initial begin
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_be_i = 4'h0; bus.core_addr_i = 32'h0; bus.core_wdata_i = 32'h0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_be_i = 4'h0; bus.dbg_addr_i = 32'h0; bus.dbg_wdata_i = 32'h0;
    bus1.core_req_i = 1'b0; bus1.core_we_i = 1'b0; bus1.core_be_i = 4'hF; bus1.core_addr_i = 32'h0; bus1.core_wdata_i = 32'h0;
    bus1.dbg_req_i = 1'b0; bus1.dbg_we_i = 1'b0; bus1.dbg_be_i = 4'h0; bus1.dbg_addr_i = 32'h0; bus1.dbg_wdata_i = 32'h0;
    test_reset();
    test_core_load();
    test_core_store();
    test_arbitration();
    test_round_robin();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    tests++; if (q0.size() !== 0) begin fails++; $display("FAIL sb0_leftover got %0d entries expected 0", q0.size()); end
    tests++; if (q1.size() !== 0) begin fails++; $display("FAIL sb1_leftover got %0d entries expected 0", q1.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
